// File: rtl/oled_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// | Package     : oled_pkg                                                  |
// | Description : Shared types and command tables for the SSD1306-class     |
// |               OLED SPI frame driver.                                    |
// | Revision    : 1.0 - initial release                                     |
// ---------------------------------------------------------------------------
package oled_pkg;

  // Top-level sequencing states
  typedef enum logic [2:0] {
    ST_RES_LOW  = 3'd0,
    ST_RES_WAIT = 3'd1,
    ST_INIT     = 3'd2,
    ST_IDLE     = 3'd3,
    ST_ADDR     = 3'd4,
    ST_DATA     = 3'd5
  } state_t;

  // Phases of a single byte: fetch from framebuffer, load shifter, shift bits
  typedef enum logic [1:0] {
    PH_FETCH = 2'd0,
    PH_LOAD  = 2'd1,
    PH_SHIFT = 2'd2
  } byte_phase_t;

  localparam int INIT_LEN          = 12;
  localparam int INIT_CONTRAST_IDX = 5;
  localparam int ADDR_LEN          = 6;

  // Init list; the contrast slot value is replaced by the top-level CONTRAST parameter
  localparam logic [7:0] INIT_CMDS [INIT_LEN] = '{
    8'h8D, 8'h14, 8'h20, 8'h00, 8'h81, 8'h00,
    8'hD9, 8'hF1, 8'hA1, 8'hC8, 8'hA4, 8'hAF
  };

  localparam logic [7:0] CMD_SET_COL  = 8'h21;
  localparam logic [7:0] CMD_SET_PAGE = 8'h22;

  // Init byte at position idx, with the contrast value substituted in
  function automatic logic [7:0] init_byte(input logic [3:0] idx, input logic [7:0] contrast);
    logic [7:0] b;
    b = 8'h00;
    if (int'(idx) == INIT_CONTRAST_IDX) begin
      b = contrast;
    end else if (int'(idx) < INIT_LEN) begin
      b = INIT_CMDS[idx];
    end
    return b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/oled_spi_byte_tx.sv
`default_nettype none
// ---------------------------------------------------------------------------
// | Module      : oled_spi_byte_tx                                          |
// | Description : Mode-0 SPI byte serialiser, MSB first, with a programmable |
// |               SCLK half-period. done pulses in the final bit cycle.     |
// | Revision    : 1.0 - initial release                                     |
// ---------------------------------------------------------------------------
module oled_spi_byte_tx #(
  parameter int SCLK_DIV = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [7:0] tx_byte,
  input  logic       dc,
  output logic       sclk,
  output logic       mosi,
  output logic       dc_out,
  output logic       done
);

  localparam int            DW       = $clog2(SCLK_DIV) + 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(SCLK_DIV - 1);

  logic [7:0]    shreg;
  logic [DW-1:0] div_cnt;
  logic [2:0]    bit_cnt;
  logic          active;
  logic          half_end;

  assign half_end = active && (div_cnt == DIV_LAST);
  assign done     = half_end && sclk && (bit_cnt == 3'd7);
  // MOSI follows the shifter MSB, which only moves as SCLK falls
  assign mosi     = shreg[7];

  // Load the byte, then walk 8 bits of low/high SCLK half-periods
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg   <= 8'h00;
      div_cnt <= '0;
      bit_cnt <= 3'd0;
      active  <= 1'b0;
      sclk    <= 1'b0;
      dc_out  <= 1'b0;
    end else if (load) begin
      shreg   <= tx_byte;
      dc_out  <= dc;
      active  <= 1'b1;
      div_cnt <= '0;
      bit_cnt <= 3'd0;
      sclk    <= 1'b0;
    end else if (active) begin
      if (half_end) begin
        div_cnt <= '0;
        if (!sclk) begin
          sclk <= 1'b1;
        end else begin
          sclk    <= 1'b0;
          shreg   <= {shreg[6:0], 1'b0};
          bit_cnt <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            active <= 1'b0;
          end
        end
      end else begin
        div_cnt <= div_cnt + DW'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/oled_spi_frame_driver.sv
`default_nettype none
// ---------------------------------------------------------------------------
// | Module      : oled_spi_frame_driver                                     |
// | Description : SSD1306-class OLED driver: reset pulse, init list, then   |
// |               single-shot or continuous frame refresh from a            |
// |               synchronous-read page/column framebuffer.                 |
// | Revision    : 1.0 - initial release                                     |
// ---------------------------------------------------------------------------
module oled_spi_frame_driver
  import oled_pkg::*;
#(
  parameter int         PAGES      = 8,
  parameter int         COLS       = 128,
  parameter int         SCLK_DIV   = 2,
  parameter int         RES_CYCLES = 1000,
  parameter logic [7:0] CONTRAST   = 8'hCF,
  localparam int        PW         = (PAGES > 1) ? $clog2(PAGES) : 1,
  localparam int        CW         = (COLS > 1) ? $clog2(COLS) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          continuous,
  output logic          pix_rd,
  output logic [PW-1:0] page,
  output logic [CW-1:0] col,
  input  logic [7:0]    pix_data,
  output logic          spi_sclk,
  output logic          spi_mosi,
  output logic          spi_dc,
  output logic          spi_cs_n,
  output logic          oled_res_n,
  output logic          init_done,
  output logic          busy,
  output logic          frame_done
);

  localparam int             RCW       = $clog2(RES_CYCLES) + 1;
  localparam logic [RCW-1:0] RES_LAST  = RCW'(RES_CYCLES - 1);
  localparam logic [PW-1:0]  LAST_PAGE = PW'(PAGES - 1);
  localparam logic [CW-1:0]  LAST_COL  = CW'(COLS - 1);
  localparam logic [3:0]     INIT_LAST = 4'(INIT_LEN - 1);
  localparam logic [3:0]     ADDR_LAST = 4'(ADDR_LEN - 1);

  state_t      state;
  state_t      next_state;
  byte_phase_t bphase;
  logic [RCW-1:0] res_cnt;
  logic [3:0]  byte_idx;
  logic        tx_load;
  logic        tx_dc;
  logic [7:0]  tx_byte_sel;
  logic        tx_done;
  logic        res_done;
  logic        list_end;
  logic        last_pixel;
  logic        in_byte_state;

  assign res_done      = (res_cnt == RES_LAST);
  assign last_pixel    = (page == LAST_PAGE) && (col == LAST_COL);
  assign list_end      = ((state == ST_INIT) && (byte_idx == INIT_LAST)) ||
                         ((state == ST_ADDR) && (byte_idx == ADDR_LAST));
  assign in_byte_state = (state == ST_INIT) || (state == ST_ADDR) || (state == ST_DATA);

  oled_spi_byte_tx #(
    .SCLK_DIV (SCLK_DIV)
  ) u_byte_tx (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (tx_load),
    .tx_byte (tx_byte_sel),
    .dc      (tx_dc),
    .sclk    (spi_sclk),
    .mosi    (spi_mosi),
    .dc_out  (spi_dc),
    .done    (tx_done)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_RES_LOW;
    end else begin
      state <= next_state;
    end
  end

  // Next-state: reset timing, command lists and frame sequencing
  always_comb begin
    next_state = state;
    case (state)
      ST_RES_LOW:  if (res_done) next_state = ST_RES_WAIT;
      ST_RES_WAIT: if (res_done) next_state = ST_INIT;
      ST_INIT:     if (tx_done && list_end) next_state = ST_IDLE;
      ST_IDLE:     if (start || continuous) next_state = ST_ADDR;
      ST_ADDR:     if (tx_done && list_end) next_state = ST_DATA;
      ST_DATA:     if (tx_done && last_pixel) next_state = continuous ? ST_ADDR : ST_IDLE;
      default:     next_state = ST_RES_LOW;
    endcase
  end

  // Outputs and byte source selection, decoded from state and byte phase
  always_comb begin
    busy        = (state != ST_IDLE);
    oled_res_n  = (state != ST_RES_LOW);
    spi_cs_n    = !in_byte_state;
    pix_rd      = (state == ST_DATA) && (bphase == PH_FETCH);
    tx_load     = (bphase == PH_LOAD);
    tx_dc       = (state == ST_DATA);
    tx_byte_sel = 8'h00;
    case (state)
      ST_INIT: tx_byte_sel = init_byte(byte_idx, CONTRAST);
      ST_ADDR: begin
        case (byte_idx)
          4'd0:    tx_byte_sel = CMD_SET_PAGE;
          4'd2:    tx_byte_sel = 8'(PAGES - 1);
          4'd3:    tx_byte_sel = CMD_SET_COL;
          4'd5:    tx_byte_sel = 8'(COLS - 1);
          default: tx_byte_sel = 8'h00;
        endcase
      end
      // Framebuffer byte arrives the cycle after the fetch strobe, i.e. in LOAD
      ST_DATA: tx_byte_sel = pix_data;
      default: tx_byte_sel = 8'h00;
    endcase
  end

  // Datapath: reset timer, list index, byte phase, pixel address, status flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_cnt    <= '0;
      byte_idx   <= 4'd0;
      bphase     <= PH_FETCH;
      page       <= '0;
      col        <= '0;
      init_done  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= (state == ST_DATA) && tx_done && last_pixel;
      if ((state == ST_INIT) && (next_state == ST_IDLE)) begin
        init_done <= 1'b1;
      end
      if (next_state != state) begin
        res_cnt  <= '0;
        byte_idx <= 4'd0;
      end else begin
        if ((state == ST_RES_LOW) || (state == ST_RES_WAIT)) begin
          res_cnt <= res_cnt + RCW'(1);
        end
        if (tx_done && (state != ST_DATA)) begin
          byte_idx <= byte_idx + 4'd1;
        end
      end
      case (bphase)
        PH_FETCH: if (in_byte_state) bphase <= PH_LOAD;
        PH_LOAD:  bphase <= PH_SHIFT;
        PH_SHIFT: if (tx_done) bphase <= PH_FETCH;
        default:  bphase <= PH_FETCH;
      endcase
      // Column-major within a page; both wrap to zero after the final byte
      if ((state == ST_DATA) && tx_done) begin
        if (col == LAST_COL) begin
          col  <= '0;
          page <= (page == LAST_PAGE) ? '0 : page + PW'(1);
        end else begin
          col <= col + CW'(1);
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_oled_spi_frame_driver.sv
`default_nettype none
// ---------------------------------------------------------------------------
// | Module      : tb_oled_spi_frame_driver                                  |
// | Description : Self-checking bench for oled_spi_frame_driver: decodes    |
// |               the SPI stream and compares it with a reference byte list. |
// | Revision    : 1.0 - initial release                                     |
// ---------------------------------------------------------------------------
module tb_oled_spi_frame_driver;

  localparam int PAGES      = 2;
  localparam int COLS       = 4;
  localparam int RES_CYCLES = 4;
  localparam int FRAME_CYC  = 14 * 18;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       continuous = 1'b0;
  logic [7:0] pix_data = 8'h00;
  logic       pix_rd, sclk, mosi, dc, cs_n, res_n, init_done, busy, frame_done;
  logic [0:0] page;
  logic [1:0] col;

  logic       start3 = 1'b0;
  logic       cont3 = 1'b0;
  logic [7:0] pix_data3 = 8'h00;
  logic       pix_rd3, sclk3, mosi3, dc3, cs3_n, res3_n, init3, busy3, frame_done3;
  logic [0:0] page3;
  logic [1:0] col3;

  int n_pass = 0;
  int n_total = 0;
  int n_fail = 0;
  int cyc = 0;

  logic [7:0] init_ref [12] = '{8'h8D, 8'h14, 8'h20, 8'h00, 8'h81, 8'hCF,
                                8'hD9, 8'hF1, 8'hA1, 8'hC8, 8'hA4, 8'hAF};
  logic [7:0] fb [PAGES][COLS];
  logic [8:0] got [$];
  logic [8:0] got3 [$];
  logic [8:0] exp_q [$];
  int         fd_times [$];
  int         base = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  oled_spi_frame_driver #(.PAGES(PAGES), .COLS(COLS), .SCLK_DIV(1), .RES_CYCLES(RES_CYCLES),
                          .CONTRAST(8'hCF)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .continuous(continuous),
    .pix_rd(pix_rd), .page(page), .col(col), .pix_data(pix_data),
    .spi_sclk(sclk), .spi_mosi(mosi), .spi_dc(dc), .spi_cs_n(cs_n),
    .oled_res_n(res_n), .init_done(init_done), .busy(busy), .frame_done(frame_done));

  oled_spi_frame_driver #(.PAGES(PAGES), .COLS(COLS), .SCLK_DIV(3), .RES_CYCLES(RES_CYCLES),
                          .CONTRAST(8'hCF)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .continuous(cont3),
    .pix_rd(pix_rd3), .page(page3), .col(col3), .pix_data(pix_data3),
    .spi_sclk(sclk3), .spi_mosi(mosi3), .spi_dc(dc3), .spi_cs_n(cs3_n),
    .oled_res_n(res3_n), .init_done(init3), .busy(busy3), .frame_done(frame_done3));

  task automatic check(string tag, logic [31:0] obs, logic [31:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Synchronous-read framebuffer model
  always @(posedge clk) if (pix_rd) pix_data <= fb[page][col];

  // SPI decoder for the SCLK_DIV=1 instance, plus frame_done timestamps
  logic       sclk_q = 1'b0;
  int         nbit = 0;
  logic [7:0] sh = 8'h00;
  always @(negedge clk) begin
    if (!rst_n) begin
      sclk_q = 1'b0;
      nbit = 0;
    end else begin
      if (sclk && !sclk_q) begin
        sh = {sh[6:0], mosi};
        nbit++;
        if (nbit == 8) begin
          got.push_back({dc, sh});
          nbit = 0;
        end
      end
      sclk_q = sclk;
      if (frame_done) fd_times.push_back(cyc);
    end
  end

  // SPI decoder and timing watch for the SCLK_DIV=3 instance
  logic       sclk3_q = 1'b0, mosi3_q = 1'b0, cs3_q = 1'b1, init3_q = 1'b0;
  int         nbit3 = 0, hi_run = 0, t_cs3 = 0, t_init3 = 0;
  logic [7:0] sh3 = 8'h00;
  always @(negedge clk) begin
    if (!rst_n) begin
      sclk3_q = 1'b0;
      nbit3 = 0;
      hi_run = 0;
      cs3_q = 1'b1;
      init3_q = 1'b0;
    end else begin
      if (sclk3) begin
        if (sclk3_q) check("div3 mosi stable while sclk high", mosi3, mosi3_q);
        else begin
          sh3 = {sh3[6:0], mosi3};
          nbit3++;
          if (nbit3 == 8) begin
            got3.push_back({dc3, sh3});
            nbit3 = 0;
          end
        end
        hi_run++;
      end else if (sclk3_q) begin
        check("div3 sclk high cycles", hi_run, 3);
        hi_run = 0;
      end
      if (!cs3_n && cs3_q) t_cs3 = cyc;
      if (init3 && !init3_q) t_init3 = cyc;
      sclk3_q = sclk3;
      mosi3_q = mosi3;
      cs3_q = cs3_n;
      init3_q = init3;
    end
  end

  task automatic push_frame();
    exp_q.push_back({1'b0, 8'h22});
    exp_q.push_back({1'b0, 8'h00});
    exp_q.push_back({1'b0, 8'(PAGES - 1)});
    exp_q.push_back({1'b0, 8'h21});
    exp_q.push_back({1'b0, 8'h00});
    exp_q.push_back({1'b0, 8'(COLS - 1)});
    for (int p = 0; p < PAGES; p++)
      for (int c = 0; c < COLS; c++)
        exp_q.push_back({1'b1, fb[p][c]});
  endtask

  task automatic compare_stream(string tag);
    logic [31:0] obs;
    check({tag, " byte count"}, got.size() - base, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      obs = (base + i < got.size()) ? 32'(got[base + i]) : 'x;
      check($sformatf("%s byte %0d {dc,byte}", tag, i), obs, 32'(exp_q[i]));
    end
    base = got.size();
    exp_q.delete();
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_fd(int n, int limit, string tag);
    int k = 0;
    while (fd_times.size() < n && k < limit) begin k++; @(negedge clk); end
    check({tag, " frame_done reached"}, 32'(fd_times.size() >= n), 1);
  endtask

  task automatic wait_pix(int p, int c, int limit, string tag);
    int k = 0;
    while (!(pix_rd && (p < 0 || (int'(page) == p && int'(col) == c))) && k < limit) begin
      k++; @(negedge clk);
    end
    check({tag, " pix_rd reached"}, 32'(pix_rd), 1);
  endtask

  task automatic reset_and_init(string tag);
    int k;
    @(posedge clk); #1 rst_n = 1'b1;
    k = 0; @(negedge clk);
    while (!res_n && k < 50) begin k++; @(negedge clk); end
    check({tag, " oled_res_n low cycles"}, k, RES_CYCLES);
    k = 0;
    while (res_n && cs_n && k < 50) begin k++; @(negedge clk); end
    check({tag, " wait after reset release"}, k, RES_CYCLES);
    k = 0;
    while (!init_done && k < 1000) begin k++; @(negedge clk); end
    check({tag, " init_done latency"}, k, 216);
    check({tag, " busy after init"}, busy, 0);
    check({tag, " cs_n after init"}, cs_n, 1);
    for (int i = 0; i < 12; i++) exp_q.push_back({1'b0, init_ref[i]});
    compare_stream({tag, " init list"});
  endtask

  task automatic check_reset_values(string tag);
    check({tag, " spi_sclk"}, sclk, 0);
    check({tag, " spi_mosi"}, mosi, 0);
    check({tag, " spi_dc"}, dc, 0);
    check({tag, " spi_cs_n"}, cs_n, 1);
    check({tag, " oled_res_n"}, res_n, 0);
    check({tag, " pix_rd"}, pix_rd, 0);
    check({tag, " page"}, page, 0);
    check({tag, " col"}, col, 0);
    check({tag, " init_done"}, init_done, 0);
    check({tag, " busy"}, busy, 1);
    check({tag, " frame_done"}, frame_done, 0);
  endtask

  initial begin
    int fd0;
    logic [31:0] obs;

    // Reset state
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    reset_and_init("boot");

    // Single-shot frame with the address-derived pattern
    for (int p = 0; p < PAGES; p++)
      for (int c = 0; c < COLS; c++)
        fb[p][c] = 8'(p * COLS + c + 16);
    fd0 = fd_times.size();
    repeat (3) @(negedge clk);
    pulse_start();
    wait_fd(fd0 + 1, 600, "single");
    repeat (20) @(negedge clk);
    check("single frame_done pulses", fd_times.size() - fd0, 1);
    check("single busy after frame", busy, 0);
    check("single cs_n after frame", cs_n, 1);
    push_frame();
    compare_stream("single frame");

    // Continuous refresh of random content, stray start, then drop continuous
    for (int p = 0; p < PAGES; p++)
      for (int c = 0; c < COLS; c++)
        fb[p][c] = 8'($urandom);
    fd0 = fd_times.size();
    @(posedge clk); #1 continuous = 1'b1;
    wait_fd(fd0 + 1, 600, "cont frame1");
    wait_pix(-1, 0, 400, "cont frame2 data");
    repeat ($urandom_range(1, 60)) @(posedge clk);
    pulse_start();
    wait_fd(fd0 + 3, 800, "cont frame3");
    wait_pix(-1, 0, 400, "cont frame4 data");
    repeat ($urandom_range(0, 40)) @(posedge clk);
    #1 continuous = 1'b0;
    repeat (400) @(negedge clk);
    check("cont frame_done total", fd_times.size() - fd0, 4);
    for (int k = 0; k < 3; k++) begin
      obs = (fd_times.size() > fd0 + k + 1) ? 32'(fd_times[fd0 + k + 1] - fd_times[fd0 + k]) : 'x;
      check($sformatf("cont frame_done interval %0d", k), obs, FRAME_CYC);
    end
    check("cont busy after stop", busy, 0);
    check("cont cs_n after stop", cs_n, 1);
    repeat (4) push_frame();
    compare_stream("continuous");

    // SCLK_DIV=3 instance: 50-cycle bytes and the same init list
    check("div3 init duration", t_init3 - t_cs3, 600);
    check("div3 init byte count", got3.size(), 12);
    for (int i = 0; i < 12; i++) begin
      obs = (i < got3.size()) ? 32'(got3[i]) : 'x;
      check($sformatf("div3 init byte %0d {dc,byte}", i), obs, 32'({1'b0, init_ref[i]}));
    end
    check("div3 idle busy", busy3, 0);
    check("div3 idle cs_n", cs3_n, 1);
    check("div3 idle res_n", res3_n, 1);
    check("div3 idle pix_rd", pix_rd3, 0);
    check("div3 idle frame_done", frame_done3, 0);
    check("div3 idle page/col", {page3, col3}, 0);

    // Asynchronous reset in the middle of a data byte
    for (int p = 0; p < PAGES; p++)
      for (int c = 0; c < COLS; c++)
        fb[p][c] = 8'($urandom);
    pulse_start();
    wait_pix(1, 2, 600, "midreset target byte");
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_values("midreset");
    repeat (3) @(negedge clk);
    base = got.size();
    exp_q.delete();
    reset_and_init("reboot");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
